matmul_scheduler: RTL

// Sequencer for the X-by-coefficient matrix-multiply datapath: counts streamed X bytes into the input RAM,

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_loop_cnt.sv | 63 ++++++
 rtl/matmul_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the matrix-multiply scheduler.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        WRITE,
        READ
    } state_t;

    localparam int unsigned DEF_X_ROWS  = 4;
    localparam int unsigned DEF_X_COLS  = 8;
    localparam int unsigned DEF_C_COLS  = 4;
    localparam int unsigned DEF_MAC_LAT = 2;

    // Counter width for a range of n values; never below one bit.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_loop_cnt.sv
// Nested row/column/k loop counter for the compute phase, with last-flags
// and the row/column values the next step will produce.
module mm_loop_cnt
    import mm_pkg::*;
#(
    parameter int unsigned ROWS = DEF_X_ROWS,
    parameter int unsigned COLS = DEF_C_COLS,
    parameter int unsigned KLEN = DEF_X_COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  k_step,
    input  logic                  rc_step,
    output logic [cw(ROWS)-1:0]   r,
    output logic [cw(COLS)-1:0]   c,
    output logic [cw(ROWS)-1:0]   r_nxt,
    output logic [cw(COLS)-1:0]   c_nxt,
    output logic                  k_last,
    output logic                  pair_last
);

    localparam int unsigned RB = cw(ROWS);
    localparam int unsigned CB = cw(COLS);
    localparam int unsigned KB = cw(KLEN);

    logic [KB-1:0] k;
    logic          c_last;
    logic          r_last;

    always_comb begin
        k_last    = (k == KB'(KLEN - 1));
        c_last    = (c == CB'(COLS - 1));
        r_last    = (r == RB'(ROWS - 1));
        pair_last = c_last && r_last;
        c_nxt     = c_last ? '0 : c + CB'(1);
        r_nxt     = r;
        if (c_last) begin
            r_nxt = r_last ? '0 : r + RB'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            c <= '0;
            r <= '0;
        end else if (clr) begin
            k <= '0;
            c <= '0;
            r <= '0;
        end else begin
            if (k_step) begin
                k <= k_last ? '0 : k + KB'(1);
            end
            if (rc_step) begin
                c <= c_nxt;
                r <= r_nxt;
            end
        end
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequencer for the X-by-coefficient matmul datapath: X load, MAC loop with
// drain and result write, then host readout handshake.
module matmul_scheduler
    import mm_pkg::*;
#(
    parameter int unsigned X_ROWS  = DEF_X_ROWS,
    parameter int unsigned X_COLS  = DEF_X_COLS,
    parameter int unsigned C_COLS  = DEF_C_COLS,
    parameter int unsigned MAC_LAT = DEF_MAC_LAT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_in,
    input  logic                               valid_input,
    input  logic                               cs_n,
    output logic                               x_we,
    output logic [$clog2(X_ROWS*X_COLS)-1:0]   x_addr,
    output logic [$clog2(C_COLS*X_COLS)-1:0]   coef_addr,
    output logic                               mac_clr,
    output logic                               mac_en,
    output logic                               web,
    output logic [$clog2(X_ROWS*C_COLS)-1:0]   res_addr,
    output logic                               ry,
    output logic                               busy,
    output logic                               finish
);

    localparam int unsigned XA = $clog2(X_ROWS * X_COLS);
    localparam int unsigned CA = $clog2(C_COLS * X_COLS);
    localparam int unsigned RA = $clog2(X_ROWS * C_COLS);
    localparam int unsigned DB = cw(MAC_LAT);

    state_t               state;
    logic [XA-1:0]        load_cnt;
    logic [RA-1:0]        rd_cnt;
    logic                 rd_done;
    logic [DB-1:0]        drain_cnt;
    logic                 lc_clr;
    logic                 k_step;
    logic                 rc_step;
    logic [cw(X_ROWS)-1:0] r, r_nxt;
    logic [cw(C_COLS)-1:0] c, c_nxt;
    logic                 k_last;
    logic                 pair_last;

    always_comb begin
        x_we    = (state == LOAD) && valid_input;
        lc_clr  = (state == IDLE);
        k_step  = (state == CALC);
        rc_step = (state == WRITE);
    end

    mm_loop_cnt #(
        .ROWS (X_ROWS),
        .COLS (C_COLS),
        .KLEN (X_COLS)
    ) u_loop (
        .clk       (clk),
        .rst       (rst),
        .clr       (lc_clr),
        .k_step    (k_step),
        .rc_step   (rc_step),
        .r         (r),
        .c         (c),
        .r_nxt     (r_nxt),
        .c_nxt     (c_nxt),
        .k_last    (k_last),
        .pair_last (pair_last)
    );

    // Outputs are loaded on the edge that enters a state so they line up
    // with the cycle the FSM spends in it; CALC walks addresses incrementally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            rd_cnt    <= '0;
            rd_done   <= 1'b0;
            drain_cnt <= '0;
            x_addr    <= '0;
            coef_addr <= '0;
            res_addr  <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            web       <= 1'b1;
            ry        <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        load_cnt <= '0;
                        x_addr   <= '0;
                    end
                end
                LOAD: begin
                    if (valid_input) begin
                        if (load_cnt == XA'(X_ROWS * X_COLS - 1)) begin
                            state     <= CALC;
                            mac_en    <= 1'b1;
                            mac_clr   <= 1'b1;
                            x_addr    <= '0;
                            coef_addr <= '0;
                        end else begin
                            load_cnt <= load_cnt + XA'(1);
                            x_addr   <= load_cnt + XA'(1);
                        end
                    end
                end
                CALC: begin
                    mac_clr <= 1'b0;
                    if (k_last) begin
                        state     <= DRAIN;
                        mac_en    <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        x_addr    <= x_addr + XA'(1);
                        coef_addr <= coef_addr + CA'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DB'(MAC_LAT - 1)) begin
                        state    <= WRITE;
                        web      <= 1'b0;
                        res_addr <= RA'(r) * RA'(C_COLS) + RA'(c);
                    end else begin
                        drain_cnt <= drain_cnt + DB'(1);
                    end
                end
                WRITE: begin
                    web <= 1'b1;
                    if (pair_last) begin
                        state    <= READ;
                        res_addr <= '0;
                        rd_cnt   <= '0;
                        rd_done  <= 1'b0;
                    end else begin
                        state     <= CALC;
                        mac_en    <= 1'b1;
                        mac_clr   <= 1'b1;
                        x_addr    <= XA'(r_nxt) * XA'(X_COLS);
                        coef_addr <= CA'(c_nxt) * CA'(X_COLS);
                    end
                end
                READ: begin
                    if (rd_done) begin
                        ry      <= 1'b0;
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                        rd_done <= 1'b0;
                        state   <= IDLE;
                    end else if (!cs_n) begin
                        ry       <= 1'b1;
                        res_addr <= rd_cnt;
                        if (rd_cnt == RA'(X_ROWS * C_COLS - 1)) begin
                            rd_done <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + RA'(1);
                        end
                    end else begin
                        ry <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
